// File: rtl/truth_table_sweeper.sv
// Drives every input vector of a combinational function in binary order, captures its 1-bit output
// into a truth table, and compares that table against a reference.
module truth_table_sweeper #(
  parameter int N_INPUTS      = 4,
  parameter int SETTLE_CYCLES = 1,
  localparam int TW           = 1 << N_INPUTS
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [TW-1:0]       expected,
  input  logic                func_out,
  output logic [N_INPUTS-1:0] vec,
  output logic                busy,
  output logic                done,
  output logic [TW-1:0]       table_out,
  output logic                table_valid,
  output logic                pass,
  output logic [N_INPUTS-1:0] first_fail
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SWEEP = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [N_INPUTS-1:0] IDX_LAST    = N_INPUTS'(TW - 1);
  localparam logic [N_INPUTS-1:0] IDX_ONE     = N_INPUTS'(1);
  localparam logic [3:0]          SETTLE_LOAD = 4'(SETTLE_CYCLES);

  logic [1:0]          state_r;
  logic [N_INPUTS-1:0] idx_r;
  logic [3:0]          settle_cnt_r;
  logic [TW-1:0]       final_table_s;
  logic [TW-1:0]       mismatch_s;
  logic                pass_s;
  logic [N_INPUTS-1:0] first_fail_s;

  // Lowest set bit position of a mismatch vector; zero when nothing is set.
  function automatic logic [N_INPUTS-1:0] lowest_set(input logic [TW-1:0] v);
    logic [N_INPUTS-1:0] r;
    r = {N_INPUTS{1'b0}};
    for (int i = TW - 1; i >= 0; i--) begin
      r = v[i] ? N_INPUTS'(i) : r;
    end
    return r;
  endfunction

  // Verdict for the table as it will stand once the current sample lands.
  always_comb begin
    final_table_s        = table_out;
    final_table_s[idx_r] = func_out;
    mismatch_s           = final_table_s ^ expected;
    pass_s               = (mismatch_s == {TW{1'b0}});
    first_fail_s         = lowest_set(mismatch_s);
  end

  // Sweep sequencer, capture register and registered result outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      idx_r        <= {N_INPUTS{1'b0}};
      settle_cnt_r <= 4'd0;
      vec          <= {N_INPUTS{1'b0}};
      busy         <= 1'b0;
      done         <= 1'b0;
      table_out    <= {TW{1'b0}};
      table_valid  <= 1'b0;
      pass         <= 1'b0;
      first_fail   <= {N_INPUTS{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            state_r      <= ST_SWEEP;
            idx_r        <= {N_INPUTS{1'b0}};
            settle_cnt_r <= SETTLE_LOAD;
            vec          <= {N_INPUTS{1'b0}};
            busy         <= 1'b1;
            table_out    <= {TW{1'b0}};
            table_valid  <= 1'b0;
            pass         <= 1'b0;
            first_fail   <= {N_INPUTS{1'b0}};
          end
        end
        ST_SWEEP: begin
          if (settle_cnt_r == 4'd0) begin
            table_out[idx_r] <= func_out;
            if (idx_r == IDX_LAST) begin
              // idx stays at the last vector so vec keeps holding it afterwards
              state_r     <= ST_DONE;
              busy        <= 1'b0;
              done        <= 1'b1;
              table_valid <= 1'b1;
              pass        <= pass_s;
              first_fail  <= first_fail_s;
            end else begin
              idx_r        <= idx_r + IDX_ONE;
              vec          <= idx_r + IDX_ONE;
              settle_cnt_r <= SETTLE_LOAD;
            end
          end else begin
            settle_cnt_r <= settle_cnt_r - 4'd1;
          end
        end
        ST_DONE: begin
          done    <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper: a 4-input/settle-1 instance and a 3-input/settle-0 instance,
// with a scoreboard of expected tables pushed at start and popped when done appears.
module tb_truth_table_sweeper;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start4 = 1'b0;
  logic        start3 = 1'b0;
  logic        tie1 = 1'b0;
  logic [15:0] expected4 = 16'h752F;
  logic [7:0]  expected3 = 8'h4A;
  logic        func4;
  logic        func3;

  logic [3:0]  vec4;
  logic        busy4, done4, valid4, pass4;
  logic [15:0] table4;
  logic [3:0]  ff4;
  logic [2:0]  vec3;
  logic        busy3, done3, valid3, pass3;
  logic [7:0]  table3;
  logic [2:0]  ff3;

  typedef struct packed {
    logic [15:0] tbl;
    logic        pass;
    logic [3:0]  ff;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  // a'b' + ad' + bc'd
  function automatic logic f4(input logic [3:0] v);
    return (!v[3] && !v[2]) || (v[3] && !v[0]) || (v[2] && !v[1] && v[0]);
  endfunction

  // abc' + a'c
  function automatic logic f3(input logic [2:0] v);
    return (v[2] && v[1] && !v[0]) || (!v[2] && v[0]);
  endfunction

  assign func4 = tie1 ? 1'b1 : f4(vec4);
  assign func3 = f3(vec3);

  truth_table_sweeper #(.N_INPUTS(4), .SETTLE_CYCLES(1)) u4 (
    .clk(clk), .reset(reset), .start(start4), .expected(expected4), .func_out(func4),
    .vec(vec4), .busy(busy4), .done(done4), .table_out(table4), .table_valid(valid4),
    .pass(pass4), .first_fail(ff4)
  );

  truth_table_sweeper #(.N_INPUTS(3), .SETTLE_CYCLES(0)) u3 (
    .clk(clk), .reset(reset), .start(start3), .expected(expected3), .func_out(func3),
    .vec(vec3), .busy(busy3), .done(done3), .table_out(table3), .table_valid(valid3),
    .pass(pass3), .first_fail(ff3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Builds the reference result from the function model and queues it.
  task automatic push4(input logic all_ones);
    exp_t e;
    logic [15:0] m;
    e.tbl = 16'h0000;
    for (int i = 0; i < 16; i++) e.tbl[i] = all_ones ? 1'b1 : f4(4'(i));
    m      = e.tbl ^ expected4;
    e.pass = (m == 16'h0000);
    e.ff   = 4'd0;
    for (int i = 15; i >= 0; i--) if (m[i]) e.ff = 4'(i);
    sb.push_back(e);
  endtask

  task automatic push3();
    exp_t e;
    logic [7:0] m;
    e.tbl = 16'h0000;
    for (int i = 0; i < 8; i++) e.tbl[i] = f3(3'(i));
    m      = e.tbl[7:0] ^ expected3;
    e.pass = (m == 8'h00);
    e.ff   = 4'd0;
    for (int i = 7; i >= 0; i--) if (m[i]) e.ff = 4'(i);
    sb.push_back(e);
  endtask

  task automatic pop4(input string tag);
    exp_t e;
    e = sb.pop_front();
    chk({tag, "_done"}, 32'(done4), 32'd1);
    chk({tag, "_busy"}, 32'(busy4), 32'd0);
    chk({tag, "_valid"}, 32'(valid4), 32'd1);
    chk({tag, "_table"}, 32'(table4), 32'(e.tbl));
    chk({tag, "_pass"}, 32'(pass4), 32'(e.pass));
    chk({tag, "_ff"}, 32'(ff4), 32'(e.ff));
  endtask

  task automatic pop3(input string tag);
    exp_t e;
    e = sb.pop_front();
    chk({tag, "_valid"}, 32'(valid3), 32'd1);
    chk({tag, "_table"}, 32'(table3), 32'(e.tbl));
    chk({tag, "_pass"}, 32'(pass3), 32'(e.pass));
    chk({tag, "_ff"}, 32'(ff3), 32'(e.ff));
  endtask

  // Pulses start and waits (bounded) for done; returns cycles counted from the start edge.
  task automatic sweep4(input logic all_ones, output int cyc);
    tie1 = all_ones;
    push4(all_ones);
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    cyc = 1;
    while (!done4 && cyc < 100) begin
      tick();
      cyc++;
    end
  endtask

  task automatic wait3(output int cyc);
    cyc = 1;
    while (!done3 && cyc < 100) begin
      tick();
      cyc++;
    end
  endtask

  initial begin
    int cyc;

    // Reset state
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_vec", 32'(vec4), 32'd0);
    chk("rst_busy", 32'(busy4), 32'd0);
    chk("rst_done", 32'(done4), 32'd0);
    chk("rst_table", 32'(table4), 32'd0);
    chk("rst_valid", 32'(valid4), 32'd0);
    chk("rst_pass", 32'(pass4), 32'd0);
    chk("rst_ff", 32'(ff4), 32'd0);

    // Tests 1, 3, 4: correct function, per-cycle vec, ignored start at vector 7
    tie1 = 1'b0;
    push4(1'b0);
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      chk($sformatf("t1_vec_c%0d", k), 32'(vec4), 32'((k - 1) / 2));
      chk($sformatf("t1_busy_c%0d", k), 32'(busy4), 32'd1);
      start4 = (k == 15);
      tick();
    end
    start4 = 1'b0;
    pop4("t1");
    chk("t1_vec_hold", 32'(vec4), 32'd15);
    tick();
    chk("t4_done_drop", 32'(done4), 32'd0);
    tick();
    chk("t4_no_resweep", 32'(busy4), 32'd0);
    chk("t4_valid_hold", 32'(valid4), 32'd1);
    chk("t4_vec_hold", 32'(vec4), 32'd15);

    // Test 2: function tied high
    sweep4(1'b1, cyc);
    chk("t2_cycles", 32'(cyc), 32'd33);
    pop4("t2");
    tick();
    tick();

    // Test 5: reset during vector 9, then a clean sweep
    tie1 = 1'b0;
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    repeat (18) tick();
    chk("t5_vec9", 32'(vec4), 32'd9);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t5_busy", 32'(busy4), 32'd0);
    chk("t5_vec", 32'(vec4), 32'd0);
    chk("t5_table", 32'(table4), 32'd0);
    chk("t5_valid", 32'(valid4), 32'd0);
    sweep4(1'b0, cyc);
    chk("t5_cycles", 32'(cyc), 32'd33);
    pop4("t5");
    tick();

    // Test 6: 3 inputs, no settle, start held for back-to-back sweeps
    push3();
    push3();
    start3 = 1'b1;
    tick();
    wait3(cyc);
    chk("t6_cycles_a", 32'(cyc), 32'd9);
    chk("t6_done_a", 32'(done3), 32'd1);
    pop3("t6a");
    tick();
    chk("t6_idle_busy", 32'(busy3), 32'd0);
    chk("t6_idle_done", 32'(done3), 32'd0);
    tick();
    chk("t6_restart_busy", 32'(busy3), 32'd1);
    chk("t6_restart_vec", 32'(vec3), 32'd0);
    chk("t6_restart_valid", 32'(valid3), 32'd0);
    wait3(cyc);
    start3 = 1'b0;
    chk("t6_cycles_b", 32'(cyc), 32'd9);
    chk("t6_done_b", 32'(done3), 32'd1);
    pop3("t6b");
    tick();
    tick();
    chk("t6_stopped", 32'(busy3), 32'd0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
